rs_enc_parity_gen: RTL
======================

Name: rs_enc_parity_gen

Overview:
Transmit-side RS(32,28) systematic encoder over GF(256), primitive polynomial 0x11D. It accepts a stream of 28 data bytes per frame and passes them through unchanged. It then appends 4 parity bytes so that the codeword evaluates to zero at roots alpha^0..alpha^3, which makes the decoder's syndrome calculator return S0..S3 = 0. It sits ahead of the interleaver/EFM path in the encode chain and mirrors the decoder's syndrome front end.

Parameters:
K, 28, data bytes per codeword; legal range 1..251; parity count fixed at 4.

Ports:
i_clk  in  1  clock, all logic on rising edge
i_res  in  1  reset, synchronous, active-high
i_data  in  8  data byte
i_valid  in  1  i_data valid
i_sof  in  1  first byte of frame, qualified by i_valid
o_ready  out  1  encoder accepts the input byte this cycle
o_data  out  8  codeword byte (data, then parity)
o_valid  out  1  o_data valid
i_ready  in  1  downstream accepts o_data
o_sof  out  1  o_data is codeword byte 0
o_par  out  1  o_data is a parity byte
o_eof  out  1  o_data is the last parity byte
o_abort  out  1  one-cycle pulse: partial frame discarded by i_sof

Behaviour:
- Interface: one clock (i_clk); reset i_res is synchronous, active-high.
- Reset: all outputs 0, state DATA, byte counter 0, LFSR p0..p3 = 0x00, parity counter 0.
- Generator g(x) = x^4 + 0x0F x^3 + 0x36 x^2 + 0x78 x + 0x40.
- Handshakes:
  - Input accept = i_valid & o_ready.
  - Output transfer = o_valid & i_ready.
  - o_ready = (state==DATA) & (!o_valid | i_ready).
  - o_data, o_valid, o_sof, o_par and o_eof are registered and stay stable while o_valid & !i_ready.
- DATA state, on accept:
  - Output register loads i_data, o_valid=1, o_sof=(cnt==0), o_par=0, o_eof=0.
  - LFSR update: f = i_data ^ p3; p3<=p2^f*0x0F; p2<=p1^f*0x36; p1<=p0^f*0x78; p0<=f*0x40.
  - cnt increments. When cnt==K-1 is accepted, cnt<=0 and state<=PARITY.
- DATA state, no accept but output transfer: o_valid<=0.
- PARITY state:
  - o_ready=0.
  - Whenever !o_valid | i_ready: output register loads p3 with o_par=1 and o_eof=(pcnt==3); LFSR shifts p3<=p2, p2<=p1, p1<=p0, p0<=0, with no feedback; pcnt increments.
  - On the 4th load: pcnt<=0, state<=DATA.
- Latency and throughput:
  - Accepted byte appears on o_data the next cycle.
  - With i_ready=1 steadily, the codeword streams K+4 bytes back-to-back and o_ready is low for exactly 4 cycles per frame.
- i_sof handling:
  - i_sof on an accept with cnt==0 is a normal frame start.
  - i_sof with cnt!=0: LFSR cleared before this byte is absorbed, cnt<=1, o_abort pulses for 1 cycle, the byte is output with o_sof=1. Already-output bytes of the partial frame are not recalled.
  - i_sof is ignored when not accepted.
- Frames without i_sof: the counter alone delimits codewords.
- i_res mid-frame or mid-parity: everything is cleared next edge; the pending output is dropped (o_valid=0).
- All GF arithmetic is bitwise XOR for add and constant multiply mod 0x11D; no carries; all 8-bit.

Decomposition:
- Shared package rs_pkg holds:
  - RS_N=32, RS_K=28, RS_NPAR=4.
  - Primitive polynomial 0x11D.
  - Generator coefficients G0..G3 = 0x40, 0x78, 0x36, 0x0F.
  - State encoding DATA/PARITY.
- Sub-modules: reuse the existing gf256_mult (x4, constant B) and gf256_sum. No new sub-module; the LFSR plus FSM stays in this block.

Test Plan:
- 27 x 0x00 then 0x01, i_ready=1 -> o_data = 28 data bytes unchanged, then 0x0F,0x36,0x78,0x40; o_par high for 4 cycles; o_eof on 0x40; o_sof on byte 0.
- 27 x 0x00 then 0x02 -> parity 0x1E,0x6C,0xF0,0x80. All-zero frame -> parity 0x00 x4.
- Random frames, loopback into the decoder's syndrome calculator -> S0..S3 = 0x00 for every frame. Flip one byte -> nonzero syndromes.
- Random i_valid/i_ready gaps on the same data as test 1 -> identical byte sequence; o_data is stable while stalled; o_ready is 0 throughout PARITY.
- i_sof asserted on the 10th byte of a frame -> o_abort 1-cycle pulse; the following 28 bytes form a valid codeword (syndromes zero).
- i_res asserted after the 2nd parity byte -> next cycle o_valid=0, o_ready=1; the next frame of 27 x 0x00 + 0x01 yields 0x0F,0x36,0x78,0x40.

Source files
------------

// File: rtl/rs_enc_parity_gen_pkg.sv
// Shared RS(32,28) constants over GF(256), primitive polynomial 0x11D,
// plus the encoder state type and a constant-multiply helper.
package rs_pkg;

  localparam int unsigned RS_N    = 32;
  localparam int unsigned RS_K    = 28;
  localparam int unsigned RS_NPAR = 4;

  localparam logic [8:0] RS_PRIM_POLY = 9'h11D;

  // g(x) = x^4 + G3 x^3 + G2 x^2 + G1 x + G0, roots alpha^0..alpha^3
  localparam logic [7:0] RS_G0 = 8'h40;
  localparam logic [7:0] RS_G1 = 8'h78;
  localparam logic [7:0] RS_G2 = 8'h36;
  localparam logic [7:0] RS_G3 = 8'h0F;

  typedef enum logic {
    DATA   = 1'b0,
    PARITY = 1'b1
  } rs_enc_state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    logic [7:0] bb;
    acc = '0;
    x   = a;
    bb  = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bb[0]) acc = acc ^ x;
      x  = x[7] ? ((x << 1) ^ RS_PRIM_POLY[7:0]) : (x << 1);
      bb = bb >> 1;
    end
    return acc;
  endfunction

endpackage

// File: rtl/rs_enc_parity_gen_gf256.sv
// GF(256) building blocks: constant multiplier and adder (XOR).
module gf256_mult
  import rs_pkg::*;
#(
  parameter logic [7:0] B = 8'h01
) (
  input  logic [7:0] a_i,
  output logic [7:0] p_o
);

  assign p_o = gf_mul(a_i, B);

endmodule

module gf256_sum (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] s_o
);

  assign s_o = a_i ^ b_i;

endmodule

// File: rtl/rs_enc_parity_gen.sv
// Systematic RS(32,28) encoder: passes K data bytes through, then emits the
// 4 parity bytes held in a generator-polynomial LFSR.
module rs_enc_parity_gen
  import rs_pkg::*;
#(
  parameter int unsigned K = RS_K
) (
  input  logic       i_clk,
  input  logic       i_res,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  input  logic       i_sof,
  output logic       o_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_sof,
  output logic       o_par,
  output logic       o_eof,
  output logic       o_abort
);

  localparam logic [7:0] KM1       = 8'(K - 1);
  localparam logic [1:0] PCNT_LAST = 2'(RS_NPAR - 1);

  rs_enc_state_e state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [1:0]    pcnt_q, pcnt_d;
  logic [7:0]    p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          sof_q, sof_d;
  logic          par_q, par_d;
  logic          eof_q, eof_d;
  logic          abort_q, abort_d;

  logic          can_load;
  logic          accept;
  logic          restart;
  logic [7:0]    cnt_eff;
  logic [7:0]    l0, l1, l2, l3;
  logic [7:0]    fb;
  logic [7:0]    m0, m1, m2, m3;
  logic [7:0]    n1, n2, n3;

  assign can_load = !valid_q | i_ready;
  assign o_ready  = (state_q == DATA) & can_load;
  assign accept   = i_valid & o_ready;
  // A mid-frame i_sof restarts the codeword: this byte is absorbed into a cleared LFSR.
  assign restart  = accept & i_sof & (cnt_q != '0);
  assign cnt_eff  = restart ? '0 : cnt_q;

  assign l0 = restart ? '0 : p0_q;
  assign l1 = restart ? '0 : p1_q;
  assign l2 = restart ? '0 : p2_q;
  assign l3 = restart ? '0 : p3_q;

  gf256_sum u_fb (.a_i(i_data), .b_i(l3), .s_o(fb));

  gf256_mult #(.B(RS_G0)) u_mul0 (.a_i(fb), .p_o(m0));
  gf256_mult #(.B(RS_G1)) u_mul1 (.a_i(fb), .p_o(m1));
  gf256_mult #(.B(RS_G2)) u_mul2 (.a_i(fb), .p_o(m2));
  gf256_mult #(.B(RS_G3)) u_mul3 (.a_i(fb), .p_o(m3));

  gf256_sum u_sum1 (.a_i(l0), .b_i(m1), .s_o(n1));
  gf256_sum u_sum2 (.a_i(l1), .b_i(m2), .s_o(n2));
  gf256_sum u_sum3 (.a_i(l2), .b_i(m3), .s_o(n3));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    p3_d    = p3_q;
    data_d  = data_q;
    valid_d = valid_q;
    sof_d   = sof_q;
    par_d   = par_q;
    eof_d   = eof_q;
    abort_d = 1'b0;

    unique case (state_q)
      DATA: begin
        if (accept) begin
          data_d  = i_data;
          valid_d = 1'b1;
          sof_d   = (cnt_eff == '0);
          par_d   = 1'b0;
          eof_d   = 1'b0;
          abort_d = restart;
          p3_d    = n3;
          p2_d    = n2;
          p1_d    = n1;
          p0_d    = m0;
          if (cnt_eff == KM1) begin
            cnt_d   = '0;
            state_d = PARITY;
          end else begin
            cnt_d = cnt_eff + 8'd1;
          end
        end else if (valid_q && i_ready) begin
          valid_d = 1'b0;
        end
      end
      PARITY: begin
        if (can_load) begin
          data_d  = p3_q;
          valid_d = 1'b1;
          sof_d   = 1'b0;
          par_d   = 1'b1;
          eof_d   = (pcnt_q == PCNT_LAST);
          p3_d    = p2_q;
          p2_d    = p1_q;
          p1_d    = p0_q;
          p0_d    = '0;
          if (pcnt_q == PCNT_LAST) begin
            pcnt_d  = '0;
            state_d = DATA;
          end else begin
            pcnt_d = pcnt_q + 2'd1;
          end
        end
      end
      default: state_d = DATA;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      state_q <= DATA;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      p3_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      par_q   <= 1'b0;
      eof_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      p3_q    <= p3_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      par_q   <= par_d;
      eof_q   <= eof_d;
      abort_q <= abort_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_sof   = sof_q;
  assign o_par   = par_q;
  assign o_eof   = eof_q;
  assign o_abort = abort_q;

endmodule
